// File: rtl/alu_rr_sched_if.sv
// Client request, ALU drive and response bundle for the round-robin ALU scheduler.
// The slave modport is the scheduler's view; the master modport is the environment's view.
interface alu_rr_sched_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_ready;
    logic [4*N_REQ-1:0] req_a;
    logic [4*N_REQ-1:0] req_b;
    logic [2*N_REQ-1:0] req_sel;

    logic [3:0]         alu_a;
    logic [3:0]         alu_b;
    logic [1:0]         alu_sel;
    logic [7:0]         alu_f;

    logic               rsp_valid;
    logic               rsp_ready;
    logic [ID_W-1:0]    rsp_id;
    logic [7:0]         rsp_data;
    logic               rsp_dz;

    modport slave (
        input  req_valid, req_a, req_b, req_sel, alu_f, rsp_ready,
        output req_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_id, rsp_data, rsp_dz
    );

    modport master (
        output req_valid, req_a, req_b, req_sel, alu_f, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_id, rsp_data, rsp_dz
    );
endinterface

// File: rtl/alu_rr_sched.sv
// Round-robin share of one external combinational ALU; result registered one cycle after accept.
// A held response with rsp_ready low blocks all grants; drain and new accept may share a cycle.
module alu_rr_sched #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sched_en,
    alu_rr_sched_if.slave    bus,
    output logic [CNT_W-1:0] op_count
);
    typedef enum logic {RSP_EMPTY, RSP_FULL} rsp_state_t;

    rsp_state_t       state_q;
    logic [ID_W-1:0]  rr_ptr_q;
    logic [ID_W-1:0]  rr_ptr_d;
    logic [ID_W-1:0]  rsp_id_q;
    logic [7:0]       rsp_data_q;
    logic             rsp_dz_q;
    logic [CNT_W-1:0] cnt_q;

    logic             slot_free;
    logic             grant_vld;
    logic [ID_W-1:0]  grant_idx;
    logic             dz_d;

    assign slot_free = (state_q == RSP_EMPTY) || bus.rsp_ready;

    // Search upward from rr_ptr; with no grant the index rests on rr_ptr so the ALU lines stay defined.
    always_comb begin
        int idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant_idx = rr_ptr_q;
        if (rst_n && sched_en && slot_free) begin
            for (int k = 0; k < N_REQ; k++) begin
                idx = (int'(rr_ptr_q) + k) % N_REQ;
                if (!grant_vld && bus.req_valid[idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = idx[ID_W-1:0];
                end
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (grant_vld) begin
            bus.req_ready[grant_idx] = 1'b1;
        end
    end

    assign bus.alu_a   = bus.req_a[grant_idx*4 +: 4];
    assign bus.alu_b   = bus.req_b[grant_idx*4 +: 4];
    assign bus.alu_sel = bus.req_sel[grant_idx*2 +: 2];

    assign dz_d     = (bus.alu_sel == 2'b11) && (bus.alu_b == 4'd0);
    assign rr_ptr_d = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RSP_EMPTY;
            rr_ptr_q   <= '0;
            rsp_id_q   <= '0;
            rsp_data_q <= '0;
            rsp_dz_q   <= 1'b0;
            cnt_q      <= '0;
        end else if (grant_vld) begin
            state_q    <= RSP_FULL;
            rr_ptr_q   <= rr_ptr_d;
            rsp_id_q   <= grant_idx;
            rsp_data_q <= bus.alu_f;
            rsp_dz_q   <= dz_d;
            cnt_q      <= cnt_q + 1'b1;
        end else if (bus.rsp_ready) begin
            state_q    <= RSP_EMPTY;
        end
    end

    assign bus.rsp_valid = (state_q == RSP_FULL);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_dz    = rsp_dz_q;
    assign op_count      = cnt_q;
endmodule

// File: doc/alu_rr_sched.md
Name: alu_rr_sched

Overview:
- Round-robin scheduler that shares one 4-bit combinational ALU (A/B 4-bit, Sel 2-bit, F 8-bit; add/sub/mul/div with divide-by-zero returning 0) among N_REQ requesters.
- Arbitrates valid/ready requests and drives the ALU operand/select lines.
- Captures the ALU result into a one-entry response register, tagged with the requester id.
- Sits between the client ports and the ALU instance; the ALU itself is external.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of the requester id; must satisfy 2**ID_W >= N_REQ.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sched_en  input  1  1 = new grants allowed; 0 = no new grants (a held response still drains).
- req_valid  input  N_REQ  per-requester request valid.
- req_ready  output  N_REQ  per-requester accept; at most one bit high per cycle.
- req_a  input  4*N_REQ  operand A; requester i uses bits [4i+3:4i].
- req_b  input  4*N_REQ  operand B, same packing as req_a.
- req_sel  input  2*N_REQ  op select; requester i uses bits [2i+1:2i]. 00 add, 01 sub, 10 mul, 11 div.
- alu_a  output  4  to ALU A.
- alu_b  output  4  to ALU B.
- alu_sel  output  2  to ALU Sel.
- alu_f  input  8  from ALU F (combinational).
- rsp_valid  output  1  response held.
- rsp_ready  input  1  consumer accepts response.
- rsp_id  output  ID_W  index of the requester the response belongs to.
- rsp_data  output  8  registered alu_f.
- rsp_dz  output  1  1 when the op was a divide with B == 0.
- op_count  output  CNT_W  number of accepted operations, wraps modulo 2**CNT_W.

Behaviour:
- Reset (async assert, sync release) clears: rsp_valid=0, rsp_id=0, rsp_data=0, rsp_dz=0, op_count=0, rr_ptr=0 (requester 0 highest priority). req_ready=0 while rst_n is low.
- Slot free: slot_free = !rsp_valid || rsp_ready.
- Grant, combinational: when sched_en && slot_free, grant the first i with req_valid[i], searching from rr_ptr upward modulo N_REQ. req_ready is one-hot at the granted index, otherwise all zero.
- ALU drive, combinational:
  - alu_a/alu_b/alu_sel carry the payload of the granted requester.
  - With no grant they carry the rr_ptr requester's payload; the value is don't-care, but the outputs must never be X after reset.
- Accept occurs at cycle T when req_valid[i] && req_ready[i]. At edge T+1:
  - rsp_valid=1, rsp_data=alu_f, rsp_id=i
  - rsp_dz=(sel==11 && b==0)
  - op_count+=1
  - rr_ptr=(i+1) mod N_REQ
- Latency: exactly one cycle from accept to rsp_valid.
- rsp_data is alu_f unmodified: sub is 8-bit two's-complement wrap, mul is the full 8-bit product, div by zero gives 0.
- Response register states:
  - EMPTY (rsp_valid=0) -> FULL on accept.
  - FULL -> EMPTY on rsp_ready with no new accept.
  - FULL -> FULL on rsp_ready with a same-cycle accept: back-to-back, one op per cycle sustained.
  - FULL and !rsp_ready: hold all rsp_* stable; req_ready all zero.
- No accept cycle: rr_ptr and op_count are unchanged.
- Requester obligations: hold valid and payload stable until ready. The scheduler never drops or reorders an accepted op.
- Fairness: a continuously valid requester is granted within N_REQ accepts.
- sched_en=0 mid-stream: the current response completes normally; no new accepts occur. Re-enabling resumes from the stored rr_ptr.
- Reset mid-operation: a held response is discarded; there is no response for an in-flight accept.
- req_valid dropping without ready is tolerated (protocol violation by the requester); no state changes.

Test Plan:
- Reset, then req0 valid with A=3, B=5, sel=01, rsp_ready=1 -> req_ready=0001 at the accept cycle; next cycle rsp_valid=1, rsp_data=0xFE, rsp_id=0, rsp_dz=0, op_count=1.
- All 4 requesters valid continuously (sel=10, A=15, B=15), rsp_ready=1 -> grants in order 0,1,2,3,0; rsp_data=0xE1 every cycle; op_count increments each cycle.
- req2 valid with A=9, B=0, sel=11 -> rsp_data=0x00, rsp_dz=1, rsp_id=2. Then A=9, B=2 -> rsp_data=0x04, rsp_dz=0.
- Backpressure: rsp_ready=0 for 5 cycles with req1 and req3 valid -> rsp_* stable, req_ready=0000. rsp_ready=1 -> next accept happens in the same cycle as the drain, with no bubble.
- sched_en=0 while req0 is valid and a response is held -> the response drains, no req_ready. sched_en=1 -> req0 is granted.
- Assert rst_n low while rsp_valid=1 and op_count=7 -> all outputs return to reset values immediately, without a clock edge.
